// File: rtl/dual_edge_level_reconstructor.sv
// -----------------------------------------------------------------------------
// dual_edge_level_reconstructor
//
// Rebuilds a level waveform from a train of single-cycle edge pulses. Each
// pulse stands for one edge, so an accepted pulse toggles the output level.
// The block also measures how long each level was held. A pulse that arrives
// too soon after the previous toggle is rejected and flagged as a glitch.
//
// Ports:
//   clk_i           - clock, all logic on the rising edge
//   rst_ni          - synchronous active-low reset
//   pulse_i         - edge event, one cycle per edge
//   resync_i        - synchronous return to SYNC; width_o/width_is_high_o hold
//   signal_o        - reconstructed level
//   glitch_o        - one-cycle flag: a pulse was rejected
//   width_valid_o   - one-cycle flag: width_o holds a completed level duration
//   width_is_high_o - 1 = width_o is a high duration, 0 = a low duration
//   width_o         - captured duration in cycles, saturating at all ones
// -----------------------------------------------------------------------------
module dual_edge_level_reconstructor #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned MIN_GAP    = 2,
   parameter logic        INIT_LEVEL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pulse_i,
   input  logic             resync_i,
   output logic             signal_o,
   output logic             glitch_o,
   output logic             width_valid_o,
   output logic             width_is_high_o,
   output logic [WIDTH-1:0] width_o
);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] MIN_GAP_C = WIDTH'(MIN_GAP);
   localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

   // Counter step that sticks at all ones, so long levels report "at least".
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (v == CNT_MAX) begin
         r = CNT_MAX;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] level_cnt_q, level_cnt_d;
   logic             signal_q, signal_d;
   logic             glitch_q, glitch_d;
   logic             width_valid_q, width_valid_d;
   logic             width_is_high_q, width_is_high_d;
   logic [WIDTH-1:0] width_q, width_d;

   // Next-state logic: acceptance, toggling, width capture and glitch flagging.
   always_comb begin
      state_d         = state_q;
      level_cnt_d     = sat_inc(level_cnt_q);
      signal_d        = signal_q;
      glitch_d        = 1'b0;
      width_valid_d   = 1'b0;
      width_is_high_d = width_is_high_q;
      width_d         = width_q;

      if (resync_i) begin
         // Resync wins over a coincident pulse; that pulse is silently dropped.
         state_d     = ST_SYNC;
         level_cnt_d = '0;
         signal_d    = INIT_LEVEL;
      end else if (pulse_i) begin
         case (state_q)
            ST_SYNC: begin
               // First edge after (re)start: no completed level to report.
               signal_d    = ~signal_q;
               level_cnt_d = CNT_ONE;
               state_d     = signal_q ? ST_LOW : ST_HIGH;
            end
            ST_LOW, ST_HIGH: begin
               if (level_cnt_q >= MIN_GAP_C) begin
                  signal_d        = ~signal_q;
                  level_cnt_d     = CNT_ONE;
                  state_d         = signal_q ? ST_LOW : ST_HIGH;
                  width_valid_d   = 1'b1;
                  width_d         = level_cnt_q;
                  width_is_high_d = (state_q == ST_HIGH);
               end else begin
                  // Too close to the last toggle: level and counter run on.
                  glitch_d = 1'b1;
               end
            end
            default: begin
               // Unreachable encoding: fall back to a clean SYNC restart.
               state_d     = ST_SYNC;
               level_cnt_d = '0;
               signal_d    = INIT_LEVEL;
            end
         endcase
      end else begin
         level_cnt_d = sat_inc(level_cnt_q);
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q         <= ST_SYNC;
         level_cnt_q     <= '0;
         signal_q        <= INIT_LEVEL;
         glitch_q        <= 1'b0;
         width_valid_q   <= 1'b0;
         width_is_high_q <= 1'b0;
         width_q         <= '0;
      end else begin
         state_q         <= state_d;
         level_cnt_q     <= level_cnt_d;
         signal_q        <= signal_d;
         glitch_q        <= glitch_d;
         width_valid_q   <= width_valid_d;
         width_is_high_q <= width_is_high_d;
         width_q         <= width_d;
      end
   end

   assign signal_o        = signal_q;
   assign glitch_o        = glitch_q;
   assign width_valid_o   = width_valid_q;
   assign width_is_high_o = width_is_high_q;
   assign width_o         = width_q;

endmodule

// File: tb/tb_dual_edge_level_reconstructor.sv
// -----------------------------------------------------------------------------
// Testbench for dual_edge_level_reconstructor (WIDTH=8, MIN_GAP=2, INIT=0).
// A time-based model (cycle of last toggle, plain integer durations) predicts
// every output after every clock; directed literal pins anchor the model.
// -----------------------------------------------------------------------------
module tb_dual_edge_level_reconstructor;

   localparam int W   = 8;
   localparam int MG  = 2;
   localparam int SAT = (1 << W) - 1;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         pulse_i;
   logic         resync_i;
   logic         signal_o;
   logic         glitch_o;
   logic         width_valid_o;
   logic         width_is_high_o;
   logic [W-1:0] width_o;

   dual_edge_level_reconstructor #(
      .WIDTH      (W),
      .MIN_GAP    (MG),
      .INIT_LEVEL (1'b0)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .pulse_i         (pulse_i),
      .resync_i        (resync_i),
      .signal_o        (signal_o),
      .glitch_o        (glitch_o),
      .width_valid_o   (width_valid_o),
      .width_is_high_o (width_is_high_o),
      .width_o         (width_o)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model: level, whether still waiting for the first edge, and the cycle
   // at which the current level first appeared on the output.
   int m_sig;
   int m_sync;
   int m_t;
   int m_glitch;
   int m_wv;
   int m_wh;
   int m_w;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, clock, compare all outputs.
   task automatic tick(input logic rst, input logic pulse, input logic resync);
      int dur;
      rst_ni   = rst;
      pulse_i  = pulse;
      resync_i = resync;
      if (!rst) begin
         m_sig = 0; m_sync = 1; m_glitch = 0; m_wv = 0; m_wh = 0; m_w = 0;
      end else if (resync) begin
         m_sig = 0; m_sync = 1; m_glitch = 0; m_wv = 0;
      end else begin
         m_glitch = 0;
         m_wv     = 0;
         if (pulse) begin
            dur = cyc - m_t + 1;
            if (m_sync != 0 || dur >= MG) begin
               if (m_sync == 0) begin
                  m_wv = 1;
                  m_wh = m_sig;
                  m_w  = (dur > SAT) ? SAT : dur;
               end
               m_sig  = 1 - m_sig;
               m_t    = cyc + 1;
               m_sync = 0;
            end else begin
               m_glitch = 1;
            end
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
      chk("signal_o", int'(signal_o), m_sig);
      chk("glitch_o", int'(glitch_o), m_glitch);
      chk("width_valid_o", int'(width_valid_o), m_wv);
      chk("width_is_high_o", int'(width_is_high_o), m_wh);
      chk("width_o", int'(width_o), m_w);
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) tick(1'b1, 1'b0, 1'b0);
   endtask

   task automatic pulse_at(input int c);
      idle_until(c);
      tick(1'b1, 1'b1, 1'b0);
   endtask

   // Pin DUT and model together against a hand-computed value.
   task automatic pin(input string name, input int act, input int mdl, input int exp);
      chk({name, "_dut"}, act, exp);
      chk({name, "_model"}, mdl, exp);
   endtask

   initial begin
      int held_w;
      int src, prev, nrep;
      m_sig = 0; m_sync = 1; m_t = 0; m_glitch = 0; m_wv = 0; m_wh = 0; m_w = 0;
      rst_ni = 1'b0; pulse_i = 1'b0; resync_i = 1'b0;

      // Reset, with a pulse attempt that must be ignored.
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      pin("rst_signal", int'(signal_o), m_sig, 0);
      pin("rst_width", int'(width_o), m_w, 0);
      cyc = 0;

      // Scenario 1: first pulse from SYNC, then a high level of 6 cycles.
      pulse_at(5);
      pin("s1_sig_high", int'(signal_o), m_sig, 1);
      pin("s1_no_report", int'(width_valid_o), m_wv, 0);
      pulse_at(11);
      pin("s1_sig_low", int'(signal_o), m_sig, 0);
      pin("s1_wv", int'(width_valid_o), m_wv, 1);
      pin("s1_w", int'(width_o), m_w, 6);
      pin("s1_wh", int'(width_is_high_o), m_wh, 1);

      // Scenario 2: low of 9, then a pulse one cycle later is a glitch.
      pulse_at(20);
      pin("s2_w", int'(width_o), m_w, 9);
      pin("s2_wh", int'(width_is_high_o), m_wh, 0);
      pulse_at(21);
      pin("s2_glitch", int'(glitch_o), m_glitch, 1);
      pin("s2_sig_kept", int'(signal_o), m_sig, 1);
      pin("s2_wv_low", int'(width_valid_o), m_wv, 0);
      pulse_at(25);
      pin("s2_w_after", int'(width_o), m_w, 5);
      pin("s2_wh_after", int'(width_is_high_o), m_wh, 1);

      // Scenario 3: a 301-cycle low level saturates the reported width.
      pulse_at(326);
      pin("s3_w_sat", int'(width_o), m_w, 255);
      pin("s3_wv", int'(width_valid_o), m_wv, 1);
      tick(1'b1, 1'b0, 1'b0);
      pin("s3_wv_single", int'(width_valid_o), m_wv, 0);

      // Scenario 4: resync with a coincident pulse while HIGH.
      idle_until(cyc + 5);
      held_w = int'(width_o);
      tick(1'b1, 1'b1, 1'b1);
      pin("s4_sig", int'(signal_o), m_sig, 0);
      pin("s4_glitch", int'(glitch_o), m_glitch, 0);
      pin("s4_wv", int'(width_valid_o), m_wv, 0);
      chk("s4_w_held", int'(width_o), held_w);
      pulse_at(cyc + 3);
      pin("s4_first_sig", int'(signal_o), m_sig, 1);
      pin("s4_first_no_report", int'(width_valid_o), m_wv, 0);

      // Scenario 5: one-cycle reset in the middle of a HIGH level.
      idle_until(cyc + 4);
      tick(1'b0, 1'b1, 1'b0);
      pin("s5_sig", int'(signal_o), m_sig, 0);
      pin("s5_w", int'(width_o), m_w, 0);
      pin("s5_wh", int'(width_is_high_o), m_wh, 0);
      pin("s5_wv", int'(width_valid_o), m_wv, 0);
      pulse_at(cyc + 2);
      pin("s5_first_sig", int'(signal_o), m_sig, 1);
      pin("s5_first_no_report", int'(width_valid_o), m_wv, 0);

      // Scenario 6: 7-high/3-low source through a Mealy dual-edge detector.
      tick(1'b1, 1'b0, 1'b1);
      prev = 0;
      nrep = 0;
      for (int k = 0; k < 60; k++) begin
         src = ((k % 10) >= 3) ? 1 : 0;
         tick(1'b1, logic'(src != prev), 1'b0);
         chk("rt_delayed_src", int'(signal_o), src);
         chk("rt_no_glitch", int'(glitch_o), 0);
         if (width_valid_o) begin
            nrep++;
            chk("rt_width", int'(width_o), width_is_high_o ? 7 : 3);
         end
         prev = src;
      end
      chk("rt_reports", nrep, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
